// File: rtl/ula_ar_mc.sv
// Multi-cycle arithmetic unit with a start/done handshake, registered result and flags.
// Add/sub ops finish in one cycle; mul/div/rem iterate one bit per cycle.
module ula_ar_mc #(
  parameter int unsigned BITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [4:0]      op,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] resu,
  output logic            o,
  output logic            c,
  output logic            s,
  output logic            z,
  output logic            err
);

  localparam int M  = BITS - 1;
  localparam int CW = $clog2(BITS + 1);

  localparam logic [4:0] OpAdd = 5'b00000;
  localparam logic [4:0] OpAdc = 5'b00001;
  localparam logic [4:0] OpInc = 5'b00011;
  localparam logic [4:0] OpSbb = 5'b00100;
  localparam logic [4:0] OpSub = 5'b00101;
  localparam logic [4:0] OpDec = 5'b00110;
  localparam logic [4:0] OpMul = 5'b01000;
  localparam logic [4:0] OpDiv = 5'b01001;
  localparam logic [4:0] OpRem = 5'b01010;

  localparam logic [BITS:0] One = (BITS + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      op_q;
  logic [BITS-1:0] acc_q, lo_q, opd_q;
  logic            busy_q, done_q, o_q, c_q, s_q, z_q, err_q;
  logic [BITS-1:0] resu_q;

  // Single-cycle datapath, evaluated on the live inputs while idle.
  logic [BITS:0]   ea, eb, sum;
  logic [BITS-1:0] sc_resu;
  logic            sc_o, sc_c, sc_err, sc_legal, sc_multi, arith;

  always_comb begin
    ea       = {1'b0, a};
    eb       = {1'b0, b};
    sum      = '0;
    sc_resu  = '0;
    sc_o     = 1'b0;
    sc_c     = 1'b0;
    sc_err   = 1'b0;
    sc_legal = 1'b1;
    sc_multi = 1'b0;
    arith    = 1'b0;
    case (op)
      OpAdd: begin
        arith = 1'b1;
        sum   = ea + eb;
        sc_o  = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OpAdc: begin
        arith = 1'b1;
        sum   = ea + eb + One;
        sc_o  = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      OpInc: begin
        arith = 1'b1;
        sum   = ea + One;
        sc_o  = !a[M] && sum[M];
      end
      OpSbb: begin
        arith = 1'b1;
        sum   = ea - eb - One;
        sc_o  = (a[M] != b[M]) && (sum[M] != a[M]);
      end
      OpSub: begin
        arith = 1'b1;
        sum   = ea - eb;
        sc_o  = (a[M] != b[M]) && (sum[M] != a[M]);
      end
      OpDec: begin
        arith = 1'b1;
        sum   = ea - One;
        sc_o  = a[M] && !sum[M];
      end
      OpMul: sc_multi = 1'b1;
      OpDiv: begin
        if (b == '0) begin
          sc_resu = '1;
          sc_err  = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OpRem: begin
        if (b == '0) begin
          sc_resu = a;
          sc_err  = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      default: begin
        sc_legal = 1'b0;
        sc_err   = 1'b1;
      end
    endcase
    if (arith) begin
      sc_resu = sum[BITS-1:0];
      sc_c    = sum[BITS];
    end
  end

  // One iteration step. Mul: acc holds the high half, lo shifts out the multiplier.
  // Div: acc is the partial remainder, lo shifts the dividend out and the quotient in.
  logic [BITS:0]   mul_sum, div_sh;
  logic            div_ge;
  logic [BITS-1:0] acc_n, lo_n;

  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh  = {acc_q, lo_q[BITS-1]};
    div_ge  = div_sh >= {1'b0, opd_q};
    acc_n   = acc_q;
    lo_n    = lo_q;
    if (op_q == OpMul) begin
      acc_n = mul_sum[BITS:1];
      lo_n  = {mul_sum[0], lo_q[BITS-1:1]};
    end else if (div_ge) begin
      acc_n = BITS'(div_sh - {1'b0, opd_q});
      lo_n  = {lo_q[BITS-2:0], 1'b1};
    end else begin
      acc_n = div_sh[BITS-1:0];
      lo_n  = {lo_q[BITS-2:0], 1'b0};
    end
  end

  logic [BITS-1:0] fin_resu;
  logic            fin_c;

  always_comb begin
    fin_resu = (op_q == OpRem) ? acc_q : lo_q;
    fin_c    = (op_q == OpMul) && (acc_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resu_q  <= '0;
      o_q     <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (sc_multi) begin
              op_q    <= op;
              opd_q   <= (op == OpMul) ? a : b;
              lo_q    <= (op == OpMul) ? b : a;
              acc_q   <= '0;
              cnt_q   <= CW'(BITS);
              busy_q  <= 1'b1;
              state_q <= StRun;
            end else begin
              done_q <= 1'b1;
              err_q  <= sc_err;
              // An illegal opcode only reports the error; the previous result stays visible.
              if (sc_legal) begin
                resu_q <= sc_resu;
                o_q    <= sc_o;
                c_q    <= sc_c;
                s_q    <= sc_resu[M];
                z_q    <= (sc_resu == '0);
              end
            end
          end
        end
        StRun: begin
          acc_q <= acc_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= StFin;
          end
        end
        StFin: begin
          resu_q  <= fin_resu;
          c_q     <= fin_c;
          o_q     <= fin_c;
          s_q     <= fin_resu[M];
          z_q     <= (fin_resu == '0);
          err_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign resu = resu_q;
  assign o    = o_q;
  assign c    = c_q;
  assign s    = s_q;
  assign z    = z_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ula_ar_mc.sv
// Scoreboard bench for ula_ar_mc at BITS=8: directed ops push expectations,
// a monitor pops and checks on every DONE pulse.
module tb_ula_ar_mc;

  localparam logic [4:0] OpAdd = 5'b00000;
  localparam logic [4:0] OpAdc = 5'b00001;
  localparam logic [4:0] OpInc = 5'b00011;
  localparam logic [4:0] OpSbb = 5'b00100;
  localparam logic [4:0] OpSub = 5'b00101;
  localparam logic [4:0] OpDec = 5'b00110;
  localparam logic [4:0] OpMul = 5'b01000;
  localparam logic [4:0] OpDiv = 5'b01001;
  localparam logic [4:0] OpRem = 5'b01010;
  localparam logic [4:0] OpBad = 5'b11111;

  logic       clk, rst_n, start;
  logic [7:0] a, b;
  logic [4:0] op;
  logic       busy, done, o, c, s, z, err;
  logic [7:0] resu;

  ula_ar_mc #(.BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .resu(resu), .o(o), .c(c), .s(s), .z(z), .err(err)
  );

  typedef struct {
    logic [7:0] resu;
    logic       o, c, s, z, err;
    int         cyc;
    int         id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ntot = 0;
  int   nbad = 0;
  int   cyc  = 0;
  int   nid  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s op#%0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        ntot++;
        nbad++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 want no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resu", mon_e.id, 32'(resu), 32'(mon_e.resu));
        chk("o", mon_e.id, 32'(o), 32'(mon_e.o));
        chk("c", mon_e.id, 32'(c), 32'(mon_e.c));
        chk("s", mon_e.id, 32'(s), 32'(mon_e.s));
        chk("z", mon_e.id, 32'(z), 32'(mon_e.z));
        chk("err", mon_e.id, 32'(err), 32'(mon_e.err));
        chk("done_cycle", mon_e.id, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // lat: edges after the accepting edge before DONE shows (0 single-cycle, BITS+1 multi).
  task automatic issue(input logic [4:0] f_op, input logic [7:0] fa, input logic [7:0] fb,
                       input logic [7:0] er, input logic eo, input logic ec, input logic es,
                       input logic ez, input logic ee, input int lat);
    exp_t e;
    @(negedge clk);
    op    = f_op;
    a     = fa;
    b     = fb;
    start = 1'b1;
    e.resu = er;
    e.o    = eo;
    e.c    = ec;
    e.s    = es;
    e.z    = ez;
    e.err  = ee;
    e.cyc  = cyc + 1 + lat;
    e.id   = nid;
    nid++;
    sb.push_back(e);
  endtask

  // Wait for all queued results; optionally count BUSY cycles and poke START at step ign_at.
  task automatic drain(input int busy_exp, input int ign_at);
    int k;
    int nb;
    k  = 0;
    nb = 0;
    @(negedge clk);
    start = 1'b0;
    while (sb.size() != 0 && k < 40) begin
      if (busy) nb++;
      if (k == ign_at) begin
        start = 1'b1;
        op    = OpDiv;
        a     = 8'h03;
        b     = 8'h05;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (k >= 40) begin
      ntot++;
      nbad++;
      $display("FAIL done_timeout: got %0d pending results want 0", sb.size());
      sb.delete();
    end
    if (busy_exp >= 0) chk("busy_cycles", nid - 1, 32'(nb), 32'(busy_exp));
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, -1, 32'(busy), 0);
    chk({nm, "_done"}, -1, 32'(done), 0);
    chk({nm, "_resu"}, -1, 32'(resu), 0);
    chk({nm, "_flags"}, -1, 32'({o, c, s, z, err}), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    #13;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //     op     a      b      resu   o     c     s     z     err  lat
    issue(OpAdd, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0); drain(0, -1);
    issue(OpSub, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0); drain(0, -1);
    issue(OpAdd, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0); drain(-1, -1);
    issue(OpDec, 8'h80, 8'h00, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0); drain(-1, -1);
    issue(OpMul, 8'h10, 8'h11, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9); drain(8, 3);
    issue(OpDiv, 8'hC8, 8'h07, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9); drain(8, -1);
    issue(OpRem, 8'hC8, 8'h07, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9); drain(-1, -1);
    issue(OpDiv, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0); drain(0, -1);
    issue(OpRem, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0); drain(0, -1);
    issue(OpAdd, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0); drain(-1, -1);
    issue(OpBad, 8'h33, 8'h44, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0); drain(0, -1);
    issue(OpInc, 8'h02, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0); drain(-1, -1);
    issue(OpInc, 8'h7F, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0); drain(-1, -1);
    // Back-to-back: each START lands in the previous op's DONE cycle.
    issue(OpAdc, 8'h03, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    issue(OpSbb, 8'h05, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    issue(OpSbb, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    issue(OpMul, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9);
    drain(-1, -1);
    issue(OpDiv, 8'hFF, 8'h10, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9); drain(-1, -1);
    issue(OpRem, 8'hFF, 8'h10, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9); drain(-1, -1);

    // Abort a multiply with reset four cycles in.
    @(negedge clk);
    op    = OpMul;
    a     = 8'h10;
    b     = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", -1, 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OpAdd, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0); drain(0, -1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
